// File: rtl/segmento_leitor.sv
// Seven-segment readback: synchronises the segment lines, filters them for stability,
// decodes the accepted pattern to a digit 0..6 and delivers changed readings over valid/ready.
module segmento_leitor #(
   parameter int ESTAVEL = 4,
   parameter int SINC    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg,
   input  logic       pronto,
   output logic [2:0] valor,
   output logic       ligado,
   output logic       erro,
   output logic       valido,
   output logic       perda
);

   localparam logic [0:0] ESPERA  = 1'b0;
   localparam logic [0:0] ENTREGA = 1'b1;
   localparam logic [7:0] ALVO    = 8'(ESTAVEL - 1);

   typedef struct packed {
      logic [2:0] valor;
      logic       ligado;
      logic       erro;
   } leitura_t;

   function automatic leitura_t decodifica(input logic [6:0] p);
      leitura_t r;
      r = '{valor: 3'd0, ligado: 1'b1, erro: 1'b0};
      case (p)
         7'h7E: r.valor = 3'd0;
         7'h30: r.valor = 3'd1;
         7'h6D: r.valor = 3'd2;
         7'h79: r.valor = 3'd3;
         7'h33: r.valor = 3'd4;
         7'h5B: r.valor = 3'd5;
         7'h1F: r.valor = 3'd6;
         7'h00: r.ligado = 1'b0;
         default: begin
            r.ligado = 1'b0;
            r.erro   = 1'b1;
         end
      endcase
      return r;
   endfunction

   logic [6:0] seg_s;

   generate
      if (SINC != 0) begin : g_sinc
         logic [6:0] s1;
         logic [6:0] s2;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s1 <= 7'h00;
               s2 <= 7'h00;
            end else begin
               s1 <= seg;
               s2 <= s1;
            end
         end
         assign seg_s = s2;
      end else begin : g_direto
         assign seg_s = seg;
      end
   endgenerate

   logic [6:0] cand;
   logic [7:0] cnt;
   logic [6:0] ultimo;
   logic [0:0] estado;
   logic       muda;
   logic       aceita;
   logic       efetivo;
   leitura_t   nova;

   // On an equal sample seg_s == cand, so seg_s is the accepted pattern in both accept cases.
   assign muda    = (seg_s != cand);
   assign aceita  = muda ? (ESTAVEL == 1) : (cnt == ALVO);
   assign efetivo = aceita && (seg_s != ultimo);
   assign nova    = decodifica(seg_s);
   assign valido  = (estado == ENTREGA);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cand   <= 7'h00;
         cnt    <= 8'd0;
         ultimo <= 7'h00;
         estado <= ESPERA;
         valor  <= 3'd0;
         ligado <= 1'b0;
         erro   <= 1'b0;
         perda  <= 1'b0;
      end else begin
         if (muda) begin
            cand <= seg_s;
            cnt  <= 8'd1;
         end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
         end

         if (efetivo) begin
            ultimo <= seg_s;
            valor  <= nova.valor;
            ligado <= nova.ligado;
            erro   <= nova.erro;
            estado <= ENTREGA;
            // Overwriting an untaken reading; a simultaneous handshake counts as taken.
            if (estado == ENTREGA && !pronto)
               perda <= 1'b1;
         end else if (estado == ENTREGA && pronto) begin
            estado <= ESPERA;
         end
      end
   end

endmodule

// File: tb/tb_segmento_leitor.sv
// Directed bench for segmento_leitor: default build plus a SINC=0/ESTAVEL=1 build.
module tb_segmento_leitor;

   typedef struct packed {
      logic [2:0] valor;
      logic       ligado;
      logic       erro;
   } rd_t;

   logic       clk = 1'b0;
   logic       rst_n, pronto;
   logic [6:0] seg;
   logic [2:0] valor;
   logic       ligado, erro, valido, perda;

   logic       rst2_n, pronto2;
   logic [6:0] seg2;
   logic [2:0] valor2;
   logic       ligado2, erro2, valido2, perda2;

   int n_chk = 0;
   int n_fail = 0;
   rd_t q[$];

   always #5 clk = ~clk;

   segmento_leitor #(.ESTAVEL(4), .SINC(1)) dut (
      .clk(clk), .rst_n(rst_n), .seg(seg), .pronto(pronto),
      .valor(valor), .ligado(ligado), .erro(erro), .valido(valido), .perda(perda));

   segmento_leitor #(.ESTAVEL(1), .SINC(0)) dut2 (
      .clk(clk), .rst_n(rst2_n), .seg(seg2), .pronto(pronto2),
      .valor(valor2), .ligado(ligado2), .erro(erro2), .valido(valido2), .perda(perda2));

   function automatic rd_t modelo(input logic [6:0] p);
      case (p)
         7'h7E: return '{3'd0, 1'b1, 1'b0};
         7'h30: return '{3'd1, 1'b1, 1'b0};
         7'h6D: return '{3'd2, 1'b1, 1'b0};
         7'h79: return '{3'd3, 1'b1, 1'b0};
         7'h33: return '{3'd4, 1'b1, 1'b0};
         7'h5B: return '{3'd5, 1'b1, 1'b0};
         7'h1F: return '{3'd6, 1'b1, 1'b0};
         7'h00: return '{3'd0, 1'b0, 1'b0};
         default: return '{3'd0, 1'b0, 1'b1};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apresenta(input logic [6:0] p);
      seg = p;
      q.push_back(modelo(p));
   endtask

   task automatic compara(input string tag);
      rd_t e;
      if (q.size() == 0) begin
         chk({tag, "_sb_empty"}, 8'd1, 8'd0);
      end else begin
         e = q.pop_front();
         chk({tag, "_valor"}, {5'd0, valor}, {5'd0, e.valor});
         chk({tag, "_ligado"}, {7'd0, ligado}, {7'd0, e.ligado});
         chk({tag, "_erro"}, {7'd0, erro}, {7'd0, e.erro});
      end
   endtask

   // Exact latency: valido holds early_v for n-1 edges, then shows the new reading at edge n.
   task automatic expect_after(input int n, input logic early_v, input string tag);
      for (int i = 1; i < n; i++) tick();
      chk({tag, "_early"}, {7'd0, valido}, {7'd0, early_v});
      tick();
      chk({tag, "_valido"}, {7'd0, valido}, 8'd1);
      compara(tag);
   endtask

   task automatic handshake(input string tag);
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk({tag, "_taken"}, {7'd0, valido}, 8'd0);
   endtask

   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      tick();
      tick();
      chk({tag, "_valor"}, {5'd0, valor}, 8'd0);
      chk({tag, "_ligado"}, {7'd0, ligado}, 8'd0);
      chk({tag, "_erro"}, {7'd0, erro}, 8'd0);
      chk({tag, "_valido"}, {7'd0, valido}, 8'd0);
      chk({tag, "_perda"}, {7'd0, perda}, 8'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; seg = 7'h00; pronto = 1'b0;
      rst2_n = 1'b0; seg2 = 7'h00; pronto2 = 1'b0;

      // 1: basic latency and handshake
      reset_dut("rst1");
      apresenta(7'h6D);
      expect_after(6, 1'b0, "t1");
      chk("t1_perda", {7'd0, perda}, 8'd0);
      handshake("t1");

      // 2: short 30 run is filtered out
      seg = 7'h30;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_no30", {7'd0, valido}, 8'd0);
      end
      apresenta(7'h79);
      expect_after(6, 1'b0, "t2");
      handshake("t2");

      // 3: error code, then blank
      apresenta(7'h7F);
      expect_after(6, 1'b0, "t3err");
      handshake("t3err");
      apresenta(7'h00);
      expect_after(6, 1'b0, "t3blank");
      handshake("t3blank");

      // 4: overwrite sets sticky perda
      apresenta(7'h33);
      expect_after(6, 1'b0, "t4a");
      chk("t4_perda0", {7'd0, perda}, 8'd0);
      apresenta(7'h5B);
      expect_after(6, 1'b1, "t4b");
      chk("t4_perda1", {7'd0, perda}, 8'd1);
      handshake("t4");
      for (int i = 0; i < 3; i++) tick();
      chk("t4_sticky", {7'd0, perda}, 8'd1);

      // 5: glitch suppression and simultaneous handshake/accept
      reset_dut("rst5");
      apresenta(7'h5B);
      expect_after(6, 1'b0, "t5a");
      handshake("t5a");
      seg = 7'h1F;
      tick(); tick();
      seg = 7'h5B;
      for (int i = 0; i < 10; i++) tick();
      chk("t5_repeat", {7'd0, valido}, 8'd0);
      apresenta(7'h33);
      expect_after(6, 1'b0, "t5b");
      apresenta(7'h79);
      for (int i = 0; i < 5; i++) tick();
      chk("t5_hold_v", {7'd0, valido}, 8'd1);
      chk("t5_hold_valor", {5'd0, valor}, 8'd4);
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      chk("t5_sim_valido", {7'd0, valido}, 8'd1);
      chk("t5_sim_perda", {7'd0, perda}, 8'd0);
      compara("t5c");
      handshake("t5c");

      // 6: reset while counting discards the run
      reset_dut("rst6a");
      seg = 7'h79;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("t6_rst_valido", {7'd0, valido}, 8'd0);
      chk("t6_rst_valor", {5'd0, valor}, 8'd0);
      chk("t6_rst_ligado", {7'd0, ligado}, 8'd0);
      chk("t6_rst_perda", {7'd0, perda}, 8'd0);
      rst_n = 1'b1;
      q.push_back(modelo(7'h79));
      expect_after(6, 1'b0, "t6");
      handshake("t6");

      // 6b: unsynchronised single-sample build
      tick();
      chk("t6b_rst_valido", {7'd0, valido2}, 8'd0);
      rst2_n = 1'b1;
      seg2 = 7'h79;
      tick();
      chk("t6b_valido", {7'd0, valido2}, 8'd1);
      chk("t6b_valor", {5'd0, valor2}, 8'd3);
      chk("t6b_ligado", {7'd0, ligado2}, 8'd1);
      seg2 = 7'h30;
      tick();
      chk("t6b_valor2", {5'd0, valor2}, 8'd1);
      chk("t6b_perda", {7'd0, perda2}, 8'd1);
      chk("t6b_erro", {7'd0, erro2}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
